// File: rtl/key_ctrl.sv
// Push-button front end: per-key 2-FF synchronizer, debouncer and press-pulse
// generator, plus hold-to-repeat stepping on the two speed keys.
module key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 30000,
    parameter int REPEAT_DELAY    = 600000,
    parameter int REPEAT_PERIOD   = 150000
) (
    input  logic       i_BCLK,
    input  logic       i_rst_n,
    input  logic [3:0] i_key_n,
    output logic       o_play,
    output logic       o_stop,
    output logic       o_speed_up,
    output logic       o_speed_down,
    output logic [3:0] o_held
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = (R_MAX > 2) ? $clog2(R_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]   RD_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]   RP_LOAD = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } rep_state_t;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] key_s;
    logic [3:0] stable_q;
    logic [3:0] stable_d;
    logic [3:0] stable_prev_q;
    logic [3:0] press_q;
    logic [1:0] rep_pulse;
    logic       conflict;

    // Synchronizer idles at 1 so keys read as released out of reset.
    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= i_key_n;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = ~sync2_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            logic [DB_W-1:0] cnt_q;
            logic [DB_W-1:0] cnt_d;
            logic            stable_next;

            always_comb begin
                cnt_d       = '0;
                stable_next = stable_q[gi];
                if (key_s[gi] != stable_q[gi]) begin
                    if (cnt_q == DB_LAST) begin
                        stable_next = key_s[gi];
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end

            always_ff @(posedge i_BCLK or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = stable_next;
        end
    endgenerate

    // Press pulse lands one cycle after the debounced level rises.
    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
        end
    end

    assign conflict = stable_q[2] & stable_q[3];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_repeat
            rep_state_t state_q;
            rep_state_t state_d;
            logic [RW-1:0] rcnt_q;
            logic [RW-1:0] rcnt_d;
            logic          rep;

            always_ff @(posedge i_BCLK or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    state_q <= S_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    state_q <= state_d;
                    rcnt_q  <= rcnt_d;
                end
            end

            // Release or both speed keys held overrides everything, pulse included.
            always_comb begin
                state_d = state_q;
                rcnt_d  = rcnt_q;
                rep     = 1'b0;
                if (!stable_q[gi+2] || conflict) begin
                    state_d = S_IDLE;
                    rcnt_d  = '0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (press_q[gi+2]) begin
                                state_d = S_DELAY;
                                rcnt_d  = RD_LOAD;
                            end
                        end
                        S_DELAY, S_REPEAT: begin
                            if (rcnt_q == '0) begin
                                rep     = 1'b1;
                                state_d = S_REPEAT;
                                rcnt_d  = RP_LOAD;
                            end else begin
                                rcnt_d = rcnt_q - RW'(1);
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                            rcnt_d  = '0;
                        end
                    endcase
                end
            end

            assign rep_pulse[gi] = rep;
        end
    endgenerate

    assign o_play       = press_q[0];
    assign o_stop       = press_q[1];
    assign o_speed_up   = press_q[2] | rep_pulse[0];
    assign o_speed_down = press_q[3] | rep_pulse[1];
    assign o_held       = stable_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl: windowed pulse-count vectors plus exact-timing
// sequences for press latency, auto-repeat, speed-key conflict and reset.
module tb_key_ctrl;

    localparam int DC = 8;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int PRESS_IDX = DC + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       o_play;
    logic       o_stop;
    logic       o_speed_up;
    logic       o_speed_down;
    logic [3:0] o_held;

    always #5 clk = ~clk;

    key_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_BCLK      (clk),
        .i_rst_n     (rst_n),
        .i_key_n     (key_n),
        .o_play      (o_play),
        .o_stop      (o_stop),
        .o_speed_up  (o_speed_up),
        .o_speed_down(o_speed_down),
        .o_held      (o_held)
    );

    typedef struct {
        logic [3:0] key_n;
        int         cycles;
        int         e_play;
        int         e_stop;
        int         e_up;
        int         e_down;
        logic [3:0] e_held;
    } vec_t;

    vec_t vecs[21];

    int n_checks = 0;
    int n_fail = 0;
    int win_idx;
    int c_play, c_stop, c_up, c_down;
    int play_q[$];
    int up_q[$];
    int exp_q[$];
    int held0_rise, held0_fall;
    logic [3:0] held_prev;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic clear_win();
        win_idx = 0;
        c_play = 0; c_stop = 0; c_up = 0; c_down = 0;
        play_q.delete();
        up_q.delete();
        held0_rise = -1;
        held0_fall = -1;
        held_prev = o_held;
    endtask

    task automatic tick();
        @(negedge clk);
        if (o_play) begin c_play++; play_q.push_back(win_idx); end
        if (o_stop) c_stop++;
        if (o_speed_up) begin c_up++; up_q.push_back(win_idx); end
        if (o_speed_down) c_down++;
        if (o_held[0] && !held_prev[0] && held0_rise < 0) held0_rise = win_idx;
        if (!o_held[0] && held_prev[0] && held0_fall < 0) held0_fall = win_idx;
        held_prev = o_held;
        win_idx++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int first;
        int r_last;
        int fall;

        vecs[0]  = '{4'hF, 50, 0, 0, 0, 0, 4'h0};
        vecs[1]  = '{4'hE, 20, 1, 0, 0, 0, 4'h1};
        vecs[2]  = '{4'hF, 20, 0, 0, 0, 0, 4'h0};
        vecs[3]  = '{4'hC, 20, 1, 1, 0, 0, 4'h3};
        vecs[4]  = '{4'hF, 20, 0, 0, 0, 0, 4'h0};
        for (int i = 0; i < 5; i++) begin
            vecs[5 + 2*i] = '{4'hD, 7, 0, 0, 0, 0, 4'h0};
            vecs[6 + 2*i] = '{4'hF, 3, 0, 0, 0, 0, 4'h0};
        end
        vecs[15] = '{4'hD, 20, 0, 1, 0, 0, 4'h2};
        vecs[16] = '{4'hF, 20, 0, 0, 0, 0, 4'h0};
        vecs[17] = '{4'h7, 15, 0, 0, 0, 1, 4'h8};
        vecs[18] = '{4'h7, 30, 0, 0, 0, 3, 4'h8};
        vecs[19] = '{4'hF, 20, 0, 0, 0, 2, 4'h0};
        vecs[20] = '{4'hF, 20, 0, 0, 0, 0, 4'h0};

        // Power-on reset
        #1;
        check("reset held", int'(o_held), 0);
        check("reset pulses", int'({o_play, o_stop, o_speed_up, o_speed_down}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven windows
        for (int i = 0; i < 21; i++) begin
            clear_win();
            key_n = vecs[i].key_n;
            run(vecs[i].cycles);
            check($sformatf("v%0d play", i), c_play, vecs[i].e_play);
            check($sformatf("v%0d stop", i), c_stop, vecs[i].e_stop);
            check($sformatf("v%0d up", i), c_up, vecs[i].e_up);
            check($sformatf("v%0d down", i), c_down, vecs[i].e_down);
            check($sformatf("v%0d held", i), int'(o_held), int'(vecs[i].e_held));
        end

        // Clean press: exact latency of held and pulse
        clear_win();
        key_n = 4'hE;
        run(20);
        first = (play_q.size() > 0) ? play_q[0] : -1;
        check("press pulse count", c_play, 1);
        check("press pulse index", first, PRESS_IDX);
        check("press held index", held0_rise, DC + 1);
        clear_win();
        key_n = 4'hF;
        run(20);
        check("release held index", held0_fall, DC + 1);
        check("release no pulse", c_play, 0);

        // Auto-repeat on speed_up
        clear_win();
        key_n = 4'hB;
        r_last = PRESS_IDX + 60;
        run(r_last + 1);
        key_n = 4'hF;
        run(30);
        fall = r_last + DC + 2;
        exp_q.delete();
        exp_q.push_back(PRESS_IDX);
        for (int t = PRESS_IDX + RD; t < fall; t += RP) exp_q.push_back(t);
        check("repeat count", up_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("repeat idx %0d", k), (k < up_q.size()) ? up_q[k] : -1, exp_q[k]);
        end

        // Speed-key conflict
        clear_win();
        key_n = 4'hB;
        run(PRESS_IDX + 10);
        key_n = 4'h3;
        run(100);
        check("conflict up pulses", c_up, 1);
        check("conflict down pulses", c_down, 1);
        check("conflict held", int'(o_held), 12);
        clear_win();
        key_n = 4'hB;
        run(60);
        check("after conflict up", c_up, 0);
        check("after conflict down", c_down, 0);
        check("after conflict held", int'(o_held), 4);
        clear_win();
        key_n = 4'hF;
        run(20);
        clear_win();
        key_n = 4'hB;
        run(40);
        check("repress up pulses", c_up, 3);
        clear_win();
        key_n = 4'hF;
        run(20);
        check("repress release up", c_up, 2);

        // Reset while play is held
        clear_win();
        key_n = 4'hE;
        run(20);
        check("pre-reset held", int'(o_held), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset held", int'(o_held), 0);
        check("async reset pulses", int'({o_play, o_stop, o_speed_up, o_speed_down}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_win();
        run(30);
        first = (play_q.size() > 0) ? play_q[0] : -1;
        check("post-reset pulse count", c_play, 1);
        check("post-reset pulse index", first, PRESS_IDX);
        key_n = 4'hF;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
